dm_byteen_responder: RTL and testbench
======================================

# dm_byteen_responder

Memory-side responder for the CPU data-memory bus. It accepts the word address, byte-lane write data and byte-enable mask that the M-stage access unit produces. It commits byte-masked writes on the clock edge and returns the full aligned word combinationally for the M stage to extract loads from. It also emits a registered write-trace record and a sticky fault flag for the checker and testbench.

## Interface
Parameters:
- DEPTH_LOG2, 12, log2 of word count (4096 words = 16 KiB)
- BASE, 32'h0000_0000, byte address of word 0

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- m_data_addr  in  32  byte address of access; bits [1:0] ignored for indexing
- m_data_wdata  in  32  lane-positioned write data
- m_data_byteen  in  4  byte-lane write enables; 4'b0000 = no write
- m_inst_addr  in  32  PC of the instruction issuing the access (trace only)
- m_data_rdata  out  32  full aligned word at m_data_addr
- wr_valid  out  1  one-cycle pulse after each committed write
- wr_pc  out  32  PC of last committed write
- wr_addr  out  32  word-aligned address of last committed write
- wr_data  out  32  full merged word after last committed write
- wr_count  out  32  number of committed writes
- fault  out  1  sticky illegal-access flag

## Operation
- Offset: off = m_data_addr - BASE (32-bit wrap). in_range = (off >> 2) < 2^DEPTH_LOG2. idx = off[DEPTH_LOG2+1:2].
- Legal byteen set: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other pattern is illegal.
- Read is combinational. m_data_rdata = mem[idx] when in_range, else 32'h0. Reads never raise fault.
- Commit condition: byteen != 0, in_range, and byteen legal.
  - On commit, for each i with byteen[i]=1: mem[idx][8i+7:8i] <= m_data_wdata[8i+7:8i]. Unenabled lanes keep their old value.
- Trace on commit:
  - wr_valid <= 1; wr_pc <= m_inst_addr; wr_addr <= {m_data_addr[31:2],2'b00}
  - wr_data <= merged word (old unenabled lanes plus new enabled lanes)
  - wr_count <= wr_count + 1, wrapping modulo 2^32
- No commit:
  - wr_valid <= 0; wr_pc, wr_addr, wr_data and wr_count hold.
- Fault:
  - fault <= 1 on any edge where byteen != 0 and either !in_range or byteen is illegal. No memory write, no trace, no count change.
  - fault stays 1 until reset.

## Timing
- Reset (reset=0, asynchronous): every mem word = 0, m_data_rdata = 0, wr_valid = 0, wr_pc = wr_addr = wr_data = 0, wr_count = 0, fault = 0. Reset overrides a write pending on the same edge.
- Read latency 0: m_data_rdata follows m_data_addr and mem within the same cycle.
- Write latency 1 edge. Read-during-write to the same word returns the pre-write value in that cycle and the new value from the next cycle.
- wr_valid asserts the cycle after the committing edge and lasts exactly one cycle per commit. Back-to-back commits keep it high continuously, and the trace fields update every cycle.
- Reset release mid-cycle: the first commit is possible on the first rising edge with reset=1.
- Address wrap: addresses below BASE wrap to large off and are out of range. The top word (idx = 2^DEPTH_LOG2-1) is in range.

## Test plan
- Reset then read: after reset, addr 32'h0000_0004 -> m_data_rdata = 0; wr_count = 0; fault = 0.
- Full word store: addr 32'h10, wdata 32'hDEADBEEF, byteen 1111, PC 32'h3000 -> next cycle rdata = 32'hDEADBEEF, wr_valid = 1 for 1 cycle, wr_pc = 32'h3000, wr_addr = 32'h10, wr_count = 1.
- Byte merge: word 32'h10 holds DEADBEEF; write wdata 32'h0000_5500 with byteen 0010 -> rdata = 32'hDEAD55EF, wr_data = 32'hDEAD55EF. Then write 32'h1234_0000 with byteen 1100 -> 32'h123455EF.
- Read-during-write: same-cycle read of a word being written with 1111 returns the old value; the next cycle returns the new value.
- Illegal access:
  - byteen 0110 at addr 32'h20 -> no change to word 32'h20, wr_valid = 0, fault = 1 and stays 1.
  - With DEPTH_LOG2=12, byteen 1111 at addr 32'h4000 -> fault = 1, rdata = 0, no write.
- Async reset mid-stream: assert reset low between edges during back-to-back stores -> all outputs go to 0 immediately. Memory reads back 0, and the store on the overlapping edge is not committed.

Source files
------------

// File: rtl/dm_byteen_responder.sv
// Data-memory responder: combinational word read, byte-masked write on the clock edge,
// registered write-trace record and a sticky illegal-access flag.

module dm_byteen_lane (
  input  logic       en_i,
  input  logic [7:0] old_i,
  input  logic [7:0] new_i,
  output logic [7:0] byte_o
);
  assign byte_o = en_i ? new_i : old_i;
endmodule

module dm_byteen_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        wr_valid,
  output logic [31:0] wr_pc,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] wr_count,
  output logic        fault
);
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;

  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  be_legal;
  logic                  any_be;
  logic                  commit;
  logic                  illegal;

  logic [NUM_LANES-1:0][7:0] old_word;
  logic [NUM_LANES-1:0][7:0] new_word;
  logic [NUM_LANES-1:0][7:0] merged;

  logic [31:0] mem_q [DEPTH];

  logic        wr_valid_q, wr_valid_d;
  logic [31:0] wr_pc_q,    wr_pc_d;
  logic [31:0] wr_addr_q,  wr_addr_d;
  logic [31:0] wr_data_q,  wr_data_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic        fault_q,    fault_d;

  // Addresses below BASE wrap to a huge offset and land out of range.
  assign off      = m_data_addr - BASE;
  assign in_range = ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign idx      = off[DEPTH_LOG2+1:2];

  always_comb begin
    be_legal = 1'b0;
    case (m_data_byteen)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign any_be  = |m_data_byteen;
  assign commit  = any_be && in_range && be_legal;
  assign illegal = any_be && (!in_range || !be_legal);

  assign old_word     = mem_q[idx];
  assign new_word     = m_data_wdata;
  assign m_data_rdata = in_range ? old_word : 32'h0;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dm_byteen_lane u_lane (
      .en_i   (m_data_byteen[l]),
      .old_i  (old_word[l]),
      .new_i  (new_word[l]),
      .byte_o (merged[l])
    );
  end

  always_comb begin
    wr_valid_d = commit;
    wr_pc_d    = wr_pc_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;
    fault_d    = fault_q | illegal;
    if (commit) begin
      wr_pc_d    = m_inst_addr;
      wr_addr_d  = {m_data_addr[31:2], 2'b00};
      wr_data_d  = merged;
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else if (commit) begin
      mem_q[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_valid_q <= 1'b0;
      wr_pc_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_pc_q    <= wr_pc_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
      fault_q    <= fault_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_pc    = wr_pc_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_dm_byteen_responder.sv
// Directed bench: writes push expected trace records; a negedge monitor pops them on wr_valid.

module tb_dm_byteen_responder;
  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        wr_valid;
  logic [31:0] wr_pc;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] wr_count;
  logic        fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } trace_t;

  trace_t      exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = 0;

  dm_byteen_responder #(.DEPTH_LOG2(12), .BASE(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .wr_valid      (wr_valid),
    .wr_pc         (wr_pc),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_count      (wr_count),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every wr_valid cycle must match the oldest outstanding expected record.
  always @(negedge clk) begin
    if (reset && wr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_valid", 32'd1, 32'd0);
      end else begin
        trace_t e;
        e = exp_q.pop_front();
        chk("trace_pc",    wr_pc,    e.pc);
        chk("trace_addr",  wr_addr,  e.addr);
        chk("trace_data",  wr_data,  e.data);
        chk("trace_count", wr_count, e.cnt);
      end
    end
  end

  // Drive one access across one rising edge; returns #1 after that edge with byteen idle.
  task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] pc, input bit commit, input logic [31:0] exp_word);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    m_inst_addr   = pc;
    if (commit) begin
      exp_cnt++;
      exp_q.push_back('{pc: pc, addr: {a[31:2], 2'b00}, data: exp_word, cnt: exp_cnt});
    end
    @(posedge clk);
    #1;
    m_data_byteen = 4'b0000;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    m_data_addr = a;
    #1;
    chk(name, m_data_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    m_data_addr   = 32'h4;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'b0000;
    m_inst_addr   = 32'h0;
    #12;
    chk("reset_rdata",    m_data_rdata, 32'h0);
    chk("reset_count",    wr_count,     32'h0);
    chk("reset_fault",    {31'b0, fault},    32'h0);
    chk("reset_wr_valid", {31'b0, wr_valid}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Full word store, then wr_valid must drop after one cycle
    acc(32'h10, 32'hDEADBEEF, 4'b1111, 32'h3000, 1, 32'hDEADBEEF);
    rd("full_store_rd", 32'h10, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("wr_valid_one_cycle", {31'b0, wr_valid}, 32'h0);

    // Byte and halfword merges; low address bits ignored
    acc(32'h10, 32'h0000_5500, 4'b0010, 32'h3004, 1, 32'hDEAD55EF);
    rd("byte_merge_rd", 32'h10, 32'hDEAD55EF);
    acc(32'h13, 32'h1234_0000, 4'b1100, 32'h3008, 1, 32'h123455EF);
    rd("half_merge_rd", 32'h10, 32'h123455EF);

    // Read-during-write returns old word, then new
    m_data_addr = 32'h10; m_data_wdata = 32'hCAFEF00D; m_data_byteen = 4'b1111;
    m_inst_addr = 32'h300C;
    #1;
    chk("rdw_old", m_data_rdata, 32'h123455EF);
    acc(32'h10, 32'hCAFEF00D, 4'b1111, 32'h300C, 1, 32'hCAFEF00D);
    rd("rdw_new", 32'h10, 32'hCAFEF00D);

    // Illegal byteen
    acc(32'h20, 32'h0000_0011, 4'b0001, 32'h3010, 1, 32'h0000_0011);
    acc(32'h20, 32'hFFFF_FFFF, 4'b0110, 32'h3014, 0, 32'h0);
    rd("illegal_be_nowrite", 32'h20, 32'h0000_0011);
    chk("illegal_be_fault",    {31'b0, fault},    32'h1);
    chk("illegal_be_no_valid", {31'b0, wr_valid}, 32'h0);
    chk("illegal_be_count",    wr_count,          32'd5);

    // Out of range, and the top word is in range
    rd("oob_rdata", 32'h4000, 32'h0);
    acc(32'h4000, 32'h5555_5555, 4'b1111, 32'h3018, 0, 32'h0);
    rd("oob_rdata_after", 32'h4000, 32'h0);
    rd("oob_no_alias", 32'h0, 32'h0);
    acc(32'h3FFC, 32'hAB00_0000, 4'b1000, 32'h301C, 1, 32'hAB00_0000);
    rd("top_word", 32'h3FFC, 32'hAB00_0000);
    acc(32'h24, 32'h0000_BEEF, 4'b0011, 32'h3020, 1, 32'h0000_BEEF);
    rd("half_low", 32'h24, 32'h0000_BEEF);
    @(posedge clk); #1;
    chk("fault_sticky", {31'b0, fault}, 32'h1);

    // Back-to-back stores keep wr_valid high
    m_data_addr = 32'h30; m_data_wdata = 32'h1111_1111; m_data_byteen = 4'b1111;
    m_inst_addr = 32'h3024;
    exp_cnt++; exp_q.push_back('{pc: 32'h3024, addr: 32'h30, data: 32'h1111_1111, cnt: exp_cnt});
    @(posedge clk); #1;
    m_data_addr = 32'h34; m_data_wdata = 32'h2222_2222; m_inst_addr = 32'h3028;
    exp_cnt++; exp_q.push_back('{pc: 32'h3028, addr: 32'h34, data: 32'h2222_2222, cnt: exp_cnt});
    @(posedge clk); #1;
    chk("b2b_valid_high", {31'b0, wr_valid}, 32'h1);
    m_data_addr = 32'h38; m_data_wdata = 32'h3333_3333; m_inst_addr = 32'h302C;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, wr_valid}, 32'h0);
    chk("arst_pc",    wr_pc,    32'h0);
    chk("arst_addr",  wr_addr,  32'h0);
    chk("arst_data",  wr_data,  32'h0);
    chk("arst_count", wr_count, 32'h0);
    chk("arst_fault", {31'b0, fault}, 32'h0);
    chk("arst_rdata", m_data_rdata, 32'h0);
    @(posedge clk); #2;
    m_data_byteen = 4'b0000;
    reset = 1'b1;
    exp_cnt = 0;
    rd("arst_mem_38", 32'h38, 32'h0);
    rd("arst_mem_30", 32'h30, 32'h0);
    rd("arst_mem_10", 32'h10, 32'h0);
    chk("arst_count_hold", wr_count, 32'h0);

    // First commit after release
    acc(32'h38, 32'h0000_0077, 4'b0001, 32'h3030, 1, 32'h0000_0077);
    rd("post_rst_rd", 32'h38, 32'h0000_0077);
    @(posedge clk); #1;
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
